uart_result_tx: RTL

Transmit-side UART block that reports a CNN classification result back to the host PC. It accepts a 4-bit result from the controller FSM when the CNN finishes. It then serialises a fixed 5-byte ASCII message, `R=<digit>\r\n`, on the UART TX line at the same baud rate the receive path uses. It sits beside the UART receiver in the top-level controller on the PLL clock domain (10.8 MHz).

---
 rtl/uart_result_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_result_tx.sv
// Serialises "R=<digit>\r\n" on a UART TX line after accepting a 4-bit CNN result.
// Define UART_TX_PARITY_EN to insert an even-parity bit after each data byte (8E1).
module uart_result_tx #(
   parameter int unsigned CLOCK_FREQ = 10_800_000,
   parameter int unsigned BAUD_RATE  = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       result_valid,
   input  logic [3:0] result,
   output logic       result_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned DIV = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_div_check
      $error("uart_result_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state, state_n;
   logic [CW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [2:0]    byte_idx, byte_n;
   logic [7:0]    digit, digit_n;
   logic          tx_n, done_n;
   logic [7:0]    cur_byte;
   logic          bit_end;

   assign result_ready = (state == IDLE);
   assign busy         = ~result_ready;
   assign bit_end      = (baud == BAUD_LAST);

   always_comb begin
      case (byte_idx)
         3'd0:    cur_byte = 8'h52;
         3'd1:    cur_byte = 8'h3D;
         3'd2:    cur_byte = digit;
         3'd3:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   // tx is computed one cycle ahead so the registered line changes exactly on bit boundaries.
   always_comb begin
      state_n = state;
      baud_n  = bit_end ? '0 : baud + CW'(1);
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      digit_n = digit;
      tx_n    = tx;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            baud_n = '0;
            if (result_valid) begin
               state_n = START;
               tx_n    = 1'b0;
               bit_n   = '0;
               byte_n  = '0;
               digit_n = (result <= 4'd9) ? (8'h30 + {4'd0, result}) : 8'h3F;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               bit_n   = '0;
               tx_n    = cur_byte[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  tx_n    = ^cur_byte;
`else
                  state_n = STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  bit_n = bit_idx + 3'd1;
                  tx_n  = cur_byte[bit_idx + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               tx_n    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (byte_idx < 3'd4) begin
                  state_n = START;
                  byte_n  = byte_idx + 3'd1;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         digit    <= '0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         digit    <= digit_n;
         tx       <= tx_n;
         done     <= done_n;
      end
   end

endmodule
